// File: rtl/bp_update_ctrl_pkg.sv
// Shared types for the gshare predictor update path: opcodes, queue entry
// layout, controller states and the PC-to-PHT-row hash used by both sides.
package bp_types;

  localparam int BP_ROW_W = 5;
  localparam int BP_COL_W = 3;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic [BP_ROW_W-1:0] row;
    logic [BP_COL_W-1:0] col;
    logic                taken;
  } bp_upd_t;

  typedef enum logic {
    INIT,
    RUN
  } bp_state_t;

  // Bit 5 is skipped so the row hash matches the predictor read path exactly.
  function automatic logic [BP_ROW_W-1:0] bp_row_idx(input logic [31:0] pc);
    return {pc[7:6], pc[4:2]};
  endfunction

endpackage

// File: rtl/bp_update_ctrl_fifo.sv
// Small synchronous FIFO holding pending PHT updates; head is combinational
// so a queued entry can be written the cycle after it is pushed.
module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is still taken when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// gshare predictor update controller: PHT init sweep after reset/flush, then
// queued EX branch outcomes drained to the PHT. Optional macro BP_PERF_CNT_EN.
module bp_update_ctrl
  import bp_types::*;
#(
  parameter int   PC_INDEX_WIDTH = 5,
  parameter int   GBHR_WIDTH     = 3,
  parameter int   QUEUE_DEPTH    = 4,
  parameter logic PHT_INIT_VAL   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      bp_flush,
  input  logic [31:0]               EX_pc,
  input  rv32i_opcode               EX_opcode,
  input  logic                      EX_br_en,
  input  logic [GBHR_WIDTH-1:0]     gbhr_in,
  input  logic                      pht_wr_ready,
  output logic                      gbhr_shift,
  output logic                      gbhr_serial_in,
  output logic                      gbhr_clear,
  output logic                      pht_we,
  output logic [PC_INDEX_WIDTH-1:0] pht_wr_row,
  output logic [GBHR_WIDTH-1:0]     pht_wr_col,
  output logic                      pht_wr_data,
  output logic                      pht_wr_init,
  output logic                      bp_ready,
  output logic                      q_full
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]               perf_upd_cnt,
  output logic [31:0]               perf_drop_cnt
`endif
);

  localparam int SWEEP_W = PC_INDEX_WIDTH + GBHR_WIDTH;
  localparam int UPD_W   = PC_INDEX_WIDTH + GBHR_WIDTH + 1;

  bp_state_t                 state;
  logic [SWEEP_W-1:0]        sweep_idx;
  logic                      in_run;
  logic                      clr;
  logic                      enq;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UPD_W-1:0]          push_data;
  logic [UPD_W-1:0]          head;
  logic [PC_INDEX_WIDTH-1:0] head_row;
  logic [GBHR_WIDTH-1:0]     head_col;
  logic                      head_taken;

  // Flush outranks a same-cycle branch: nothing is queued or shifted then.
  assign in_run    = (state == RUN) & ~rst;
  assign clr       = rst | bp_flush;
  assign enq       = in_run & ~bp_flush & (EX_opcode == op_br) & ~stall;
  assign pop       = in_run & ~bp_flush & ~fifo_empty & pht_wr_ready;
  assign push      = enq & (~fifo_full | pop);
  assign push_data = {PC_INDEX_WIDTH'(bp_row_idx(EX_pc)), gbhr_in, EX_br_en};
  assign {head_row, head_col, head_taken} = head;

  bp_upd_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (UPD_W)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (rst || bp_flush) begin
      state     <= INIT;
      sweep_idx <= '0;
    end else begin
      case (state)
        INIT: begin
          if (pht_wr_ready) begin
            sweep_idx <= sweep_idx + SWEEP_W'(1);
            if (&sweep_idx) state <= RUN;
          end
        end
        RUN: state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

  // The sweep owns the write port in INIT; in RUN the queue head drives it.
  always_comb begin
    pht_we      = 1'b0;
    pht_wr_init = 1'b0;
    pht_wr_data = head_taken;
    pht_wr_row  = head_row;
    pht_wr_col  = head_col;
    if (!rst) begin
      if (state == INIT) begin
        pht_we      = 1'b1;
        pht_wr_init = 1'b1;
        pht_wr_data = PHT_INIT_VAL;
        pht_wr_row  = sweep_idx[SWEEP_W-1:GBHR_WIDTH];
        pht_wr_col  = sweep_idx[GBHR_WIDTH-1:0];
      end else if (!bp_flush && !fifo_empty) begin
        pht_we = 1'b1;
      end
    end
  end

  assign gbhr_shift     = enq;
  assign gbhr_serial_in = EX_br_en;
  assign gbhr_clear     = rst | (state == INIT);
  assign bp_ready       = in_run;
  assign q_full         = fifo_full & ~rst;

`ifdef BP_PERF_CNT_EN
  // Counters survive flushes so they span the whole run since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_upd_cnt  <= '0;
      perf_drop_cnt <= '0;
    end else begin
      if (pop && (perf_upd_cnt != '1))
        perf_upd_cnt <= perf_upd_cnt + 32'd1;
      if (enq && !push && (perf_drop_cnt != '1))
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl with a scoreboard of expected PHT updates.
module tb_bp_update_ctrl;
  import bp_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        bp_flush;
  logic [31:0] EX_pc;
  rv32i_opcode EX_opcode;
  logic        EX_br_en;
  logic [2:0]  gbhr_in;
  logic        pht_wr_ready;
  logic        gbhr_shift;
  logic        gbhr_serial_in;
  logic        gbhr_clear;
  logic        pht_we;
  logic [4:0]  pht_wr_row;
  logic [2:0]  pht_wr_col;
  logic        pht_wr_data;
  logic        pht_wr_init;
  logic        bp_ready;
  logic        q_full;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_upd_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  typedef struct {
    logic [4:0] row;
    logic [2:0] col;
    logic       taken;
  } exp_t;

  exp_t        sb[$];
  int          checks  = 0;
  int          errors  = 0;
  int          wr_seen = 0;
  logic [31:0] ovf_pc[6]    = '{32'h0000_0004, 32'h0000_0048, 32'h0000_0090,
                                32'h0000_00DC, 32'h0000_0010, 32'h0000_00FC};
  logic        ovf_tk[6]    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [2:0]  ovf_hist[6]  = '{3'd0, 3'd7, 3'd2, 3'd5, 3'd1, 3'd6};

  bp_update_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .bp_flush       (bp_flush),
    .EX_pc          (EX_pc),
    .EX_opcode      (EX_opcode),
    .EX_br_en       (EX_br_en),
    .gbhr_in        (gbhr_in),
    .pht_wr_ready   (pht_wr_ready),
    .gbhr_shift     (gbhr_shift),
    .gbhr_serial_in (gbhr_serial_in),
    .gbhr_clear     (gbhr_clear),
    .pht_we         (pht_we),
    .pht_wr_row     (pht_wr_row),
    .pht_wr_col     (pht_wr_col),
    .pht_wr_data    (pht_wr_data),
    .pht_wr_init    (pht_wr_init),
    .bp_ready       (bp_ready),
    .q_full         (q_full)
`ifdef BP_PERF_CNT_EN
    ,
    .perf_upd_cnt   (perf_upd_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] model_row(input logic [31:0] pc);
    logic [4:0] r;
    r = {pc[7], pc[6], pc[4], pc[3], pc[2]};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after a falling edge, then let them settle.
  task automatic applyStimulus(input logic br, input logic [31:0] pc, input logic taken,
                               input logic [2:0] hist, input logic stl, input logic rdy,
                               input logic fl);
    if (br) EX_opcode = op_br;
    else    EX_opcode = op_imm;
    EX_pc        = pc;
    EX_br_en     = taken;
    gbhr_in      = hist;
    stall        = stl;
    pht_wr_ready = rdy;
    bp_flush     = fl;
    #1;
  endtask

  task automatic pushExpected(input logic [31:0] pc, input logic taken, input logic [2:0] hist);
    exp_t e;
    e.row   = model_row(pc);
    e.col   = hist;
    e.taken = taken;
    sb.push_back(e);
  endtask

  // Any completed non-init write this cycle must match the scoreboard head.
  task automatic tick();
    exp_t e;
    if (pht_we && !pht_wr_init && pht_wr_ready) begin
      wr_seen++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_write observed=%0h expected=none",
               {pht_wr_row, pht_wr_col, pht_wr_data});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("upd_write", {23'd0, pht_wr_row, pht_wr_col, pht_wr_data},
                    {23'd0, e.row, e.col, e.taken});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int idx;

    rst = 1'b1;
    applyStimulus(1'b1, 32'h0000_00C8, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_outputs", {27'd0, pht_we, gbhr_shift, gbhr_clear, bp_ready, q_full},
                {27'd0, 5'b00100});

    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("sweep", {20'd0, pht_we, pht_wr_init, pht_wr_row, pht_wr_col, pht_wr_data,
                            gbhr_clear, bp_ready},
                  {20'd0, 1'b1, 1'b1, i[7:0], 1'b0, 1'b1, 1'b0});
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("ready_257", {29'd0, bp_ready, gbhr_clear, pht_we}, {29'd0, 3'b100});
    tick();

    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    tick();
    cyc = 0;
    idx = 0;
    while (cyc < 2000) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, (cyc % 2 == 1), 1'b0);
      if (bp_ready) break;
      if (pht_wr_ready) begin
        checkOutput("bp_sweep_idx", {23'd0, pht_we, pht_wr_row, pht_wr_col},
                    {23'd0, 1'b1, idx[7:0]});
        idx++;
      end
      cyc++;
      tick();
    end
    checkOutput("bp_init_cycles", cyc, 512);
    checkOutput("bp_sweep_count", idx, 256);
    tick();

    applyStimulus(1'b1, 32'h0000_00C8, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0);
    checkOutput("single_shift", {29'd0, gbhr_shift, gbhr_serial_in, pht_we}, {29'd0, 3'b110});
    pushExpected(32'h0000_00C8, 1'b1, 3'b101);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("single_we", {30'd0, pht_we, pht_wr_init}, {30'd0, 2'b10});
    checkOutput("single_row", {27'd0, pht_wr_row}, {27'd0, 5'b11010});
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("single_idle", {31'd0, pht_we}, 32'd0);
    tick();

    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, ovf_pc[k], ovf_tk[k], ovf_hist[k], 1'b0, 1'b0, 1'b0);
      checkOutput("ovf_qfull", {31'd0, q_full}, {31'd0, (sb.size() == 4)});
      checkOutput("ovf_shift", {30'd0, gbhr_shift, gbhr_serial_in}, {30'd0, 1'b1, ovf_tk[k]});
      if (sb.size() < 4) pushExpected(ovf_pc[k], ovf_tk[k], ovf_hist[k]);
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_full_hold", {31'd0, q_full}, 32'd1);
    tick();
    wr_seen = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    checkOutput("ovf_writes", wr_seen, 4);
    checkOutput("ovf_sb_left", sb.size(), 0);
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("ovf_drained", {30'd0, q_full, pht_we}, 32'd0);
`ifdef BP_PERF_CNT_EN
    checkOutput("perf_upd", perf_upd_cnt, 32'd5);
    checkOutput("perf_drop", perf_drop_cnt, 32'd2);
`endif
    tick();

    applyStimulus(1'b1, 32'h0000_0044, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_no_shift", {31'd0, gbhr_shift}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_no_push", {31'd0, pht_we}, 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, ovf_pc[k], ovf_tk[k], ovf_hist[k], 1'b0, 1'b0, 1'b0);
      pushExpected(ovf_pc[k], ovf_tk[k], ovf_hist[k]);
      tick();
    end
    applyStimulus(1'b1, 32'h0000_00C8, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_cycle", {30'd0, pht_we, gbhr_shift}, 32'd0);
    tick();
    sb.delete();
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_restart", {21'd0, bp_ready, pht_we, pht_wr_init, pht_wr_row, pht_wr_col},
                {21'd0, 3'b011, 8'd0});
    tick();
    cyc = 1;
    while (cyc < 600) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      if (bp_ready) break;
      cyc++;
      tick();
    end
    checkOutput("flush_init_cycles", cyc, 256);
    checkOutput("flush_no_stale", {31'd0, pht_we}, 32'd0);
`ifdef BP_PERF_CNT_EN
    checkOutput("perf_upd_flush", perf_upd_cnt, 32'd5);
    checkOutput("perf_drop_flush", perf_drop_cnt, 32'd2);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
